mill_modif_frame_rx: RTL and testbench

//  Parametrised modified-Miller (ISO14443-A PCD->PICC) receiver: oversamples the demodulated pause line,

---
 rtl/mill_modif_pkg.sv | 16 +
 rtl/mill_pause_sync.sv | 36 +++
 rtl/mill_modif_frame_rx.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mill_modif_frame_rx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mill_modif_pkg.sv
// Shared types and ETU threshold helpers for the modified-Miller receiver.
package mill_modif_pkg;

  typedef enum logic [1:0] {SYM_X, SYM_Y, SYM_Z} sym_t;

  typedef enum logic {ST_IDLE, ST_RX} state_t;

  function automatic int unsigned etu_quarter(input int unsigned etu);
    return etu / 4;
  endfunction

  function automatic int unsigned etu_three_quarter(input int unsigned etu);
    return (3 * etu) / 4;
  endfunction

endpackage

// File: rtl/mill_pause_sync.sv
// Two-flop synchroniser for the pause line plus a one-cycle strobe on entry into a pause.
module mill_pause_sync #(
  parameter bit PAUSE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_i,
  output logic edge_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic last_q, last_d;

  always_comb begin
    meta_d = data_i;
    sync_d = meta_q;
    last_d = sync_q;
  end

  // Reset to the idle (non-pause) level so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= ~PAUSE_LVL;
      sync_q <= ~PAUSE_LVL;
      last_q <= ~PAUSE_LVL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign edge_o = (sync_q == PAUSE_LVL) && (last_q != PAUSE_LVL);

endmodule

// File: rtl/mill_modif_frame_rx.sv
// Modified-Miller receiver: ETU classifier, SOF/EOF framing, one-bit holdback and byte assembly.
module mill_modif_frame_rx
  import mill_modif_pkg::*;
#(
  parameter int unsigned ETU_CYCLES = 8,
  parameter bit          PAUSE_LVL  = 1'b0,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_enable,
  input  logic       in_data,
  output logic       out_bit,
  output logic       out_bit_valid,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic [2:0] last_bits,
  output logic       parity_err,
  output logic       sof,
  output logic       eof,
  output logic       coding_err,
  output logic       busy
);

  localparam int unsigned PhaseW = $clog2(ETU_CYCLES);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(ETU_CYCLES - 1);
  localparam logic [PhaseW-1:0] PhaseQ1   = PhaseW'(etu_quarter(ETU_CYCLES));
  localparam logic [PhaseW-1:0] PhaseQ3   = PhaseW'(etu_three_quarter(ETU_CYCLES));

  logic pause_edge;

  mill_pause_sync #(
    .PAUSE_LVL(PAUSE_LVL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(in_data),
    .edge_o(pause_edge)
  );

  state_t            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              first_q, first_d;
  logic              seen_q, seen_d;
  logic              early_q, early_d;
  logic              bad_q, bad_d;
  logic              prev_q, prev_d;
  logic              hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;

  logic       out_bit_q, out_bit_d;
  logic       out_bit_valid_q, out_bit_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       out_byte_valid_q, out_byte_valid_d;
  logic [2:0] last_bits_q, last_bits_d;
  logic       parity_err_q, parity_err_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       coding_err_q, coding_err_d;
  logic       busy_q, busy_d;

  logic seen_now, early_now, bad_now;
  sym_t sym;
  logic decoded, new_bit, end_frame, abort;

  // Classification includes an edge arriving in the closing cycle itself.
  always_comb begin
    seen_now  = seen_q | pause_edge;
    early_now = early_q | (pause_edge & (phase_q < PhaseQ1));
    bad_now   = bad_q | (seen_q & pause_edge) | (pause_edge & (phase_q >= PhaseQ3));
    if (!seen_now) begin
      sym = SYM_Y;
    end else if (early_now) begin
      sym = SYM_Z;
    end else begin
      sym = SYM_X;
    end
  end

  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    first_d          = first_q;
    seen_d           = seen_q;
    early_d          = early_q;
    bad_d            = bad_q;
    prev_d           = prev_q;
    hold_d           = hold_q;
    hold_vld_d       = hold_vld_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    out_bit_d        = out_bit_q;
    out_bit_valid_d  = 1'b0;
    out_byte_d       = out_byte_q;
    out_byte_valid_d = 1'b0;
    last_bits_d      = last_bits_q;
    parity_err_d     = 1'b0;
    sof_d            = 1'b0;
    eof_d            = 1'b0;
    coding_err_d     = 1'b0;
    decoded          = 1'b0;
    new_bit          = 1'b0;
    end_frame        = 1'b0;
    abort            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The SOF edge cycle is phase 0 of the SOF ETU, which is tracked but never decoded.
        if (pause_edge) begin
          state_d    = ST_RX;
          phase_d    = PhaseW'(1);
          first_d    = 1'b1;
          seen_d     = 1'b1;
          early_d    = 1'b1;
          bad_d      = 1'b0;
          prev_d     = 1'b0;
          hold_vld_d = 1'b0;
          data_d     = '0;
          cnt_d      = '0;
          sof_d      = 1'b1;
        end
      end
      ST_RX: begin
        phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseW'(1);
        seen_d  = seen_now;
        early_d = early_now;
        bad_d   = bad_now;
        if (phase_q == PhaseLast) begin
          seen_d  = 1'b0;
          early_d = 1'b0;
          bad_d   = 1'b0;
          first_d = 1'b0;
          if (bad_now) begin
            abort = 1'b1;
          end else if (!first_q) begin
            unique case (sym)
              SYM_X: begin
                decoded = 1'b1;
                new_bit = 1'b1;
              end
              SYM_Z: begin
                if (prev_q) begin
                  abort = 1'b1;
                end else begin
                  decoded = 1'b1;
                end
              end
              default: begin
                if (prev_q) begin
                  decoded = 1'b1;
                end else begin
                  end_frame = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase

    if (decoded) begin
      if (hold_vld_q) begin
        out_bit_d       = hold_q;
        out_bit_valid_d = 1'b1;
        if (PARITY_EN && (cnt_q == 4'd8)) begin
          out_byte_d       = data_q;
          parity_err_d     = ~^{data_q, hold_q};
          out_byte_valid_d = 1'b1;
          last_bits_d      = 3'd0;
          data_d           = '0;
          cnt_d            = '0;
        end else if (!PARITY_EN && (cnt_q == 4'd7)) begin
          out_byte_d       = {hold_q, data_q[6:0]};
          out_byte_valid_d = 1'b1;
          last_bits_d      = 3'd0;
          data_d           = '0;
          cnt_d            = '0;
        end else begin
          data_d[cnt_q[2:0]] = hold_q;
          cnt_d              = cnt_q + 4'd1;
        end
      end
      hold_d     = new_bit;
      hold_vld_d = 1'b1;
      prev_d     = new_bit;
    end

    // The held 0 belongs to the EOF pattern and is dropped; any partial byte is flushed.
    if (end_frame) begin
      state_d = ST_IDLE;
      eof_d   = 1'b1;
      if (cnt_q != 4'd0) begin
        out_byte_d       = data_q;
        last_bits_d      = cnt_q[2:0];
        out_byte_valid_d = 1'b1;
      end
    end

    if (abort) begin
      state_d      = ST_IDLE;
      coding_err_d = 1'b1;
    end

    if (!in_enable) begin
      state_d          = ST_IDLE;
      out_bit_valid_d  = 1'b0;
      out_byte_valid_d = 1'b0;
      parity_err_d     = 1'b0;
      sof_d            = 1'b0;
      eof_d            = 1'b0;
      coding_err_d     = 1'b0;
    end

    if (end_frame || abort || !in_enable) begin
      hold_vld_d = 1'b0;
      data_d     = '0;
      cnt_d      = '0;
      seen_d     = 1'b0;
      early_d    = 1'b0;
      bad_d      = 1'b0;
      first_d    = 1'b0;
    end

    busy_d = (state_d == ST_RX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      phase_q          <= '0;
      first_q          <= 1'b0;
      seen_q           <= 1'b0;
      early_q          <= 1'b0;
      bad_q            <= 1'b0;
      prev_q           <= 1'b0;
      hold_q           <= 1'b0;
      hold_vld_q       <= 1'b0;
      data_q           <= '0;
      cnt_q            <= '0;
      out_bit_q        <= 1'b0;
      out_bit_valid_q  <= 1'b0;
      out_byte_q       <= '0;
      out_byte_valid_q <= 1'b0;
      last_bits_q      <= '0;
      parity_err_q     <= 1'b0;
      sof_q            <= 1'b0;
      eof_q            <= 1'b0;
      coding_err_q     <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      first_q          <= first_d;
      seen_q           <= seen_d;
      early_q          <= early_d;
      bad_q            <= bad_d;
      prev_q           <= prev_d;
      hold_q           <= hold_d;
      hold_vld_q       <= hold_vld_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      out_bit_q        <= out_bit_d;
      out_bit_valid_q  <= out_bit_valid_d;
      out_byte_q       <= out_byte_d;
      out_byte_valid_q <= out_byte_valid_d;
      last_bits_q      <= last_bits_d;
      parity_err_q     <= parity_err_d;
      sof_q            <= sof_d;
      eof_q            <= eof_d;
      coding_err_q     <= coding_err_d;
      busy_q           <= busy_d;
    end
  end

  assign out_bit        = out_bit_q;
  assign out_bit_valid  = out_bit_valid_q;
  assign out_byte       = out_byte_q;
  assign out_byte_valid = out_byte_valid_q;
  assign last_bits      = last_bits_q;
  assign parity_err     = parity_err_q;
  assign sof            = sof_q;
  assign eof            = eof_q;
  assign coding_err     = coding_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mill_modif_frame_rx.sv
// Bench: a parity and a plain receiver share one pause line; scoreboards hold expected bits/bytes.
module tb_mill_modif_frame_rx;

  localparam int Etu = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_enable = 1'b0;
  logic in_data = 1'b1;

  always #5 clk = ~clk;

  logic       bit_p, bitv_p, bytev_p, perr_p, sof_p, eof_p, cerr_p, busy_p;
  logic [7:0] byte_p;
  logic [2:0] last_p;
  logic       bit_n, bitv_n, bytev_n, perr_n, sof_n, eof_n, cerr_n, busy_n;
  logic [7:0] byte_n;
  logic [2:0] last_n;

  mill_modif_frame_rx #(
    .ETU_CYCLES(Etu),
    .PAUSE_LVL (1'b0),
    .PARITY_EN (1'b1)
  ) u_dut_par (
    .clk(clk), .rst_n(rst_n), .in_enable(in_enable), .in_data(in_data),
    .out_bit(bit_p), .out_bit_valid(bitv_p), .out_byte(byte_p), .out_byte_valid(bytev_p),
    .last_bits(last_p), .parity_err(perr_p), .sof(sof_p), .eof(eof_p),
    .coding_err(cerr_p), .busy(busy_p)
  );

  mill_modif_frame_rx #(
    .ETU_CYCLES(Etu),
    .PAUSE_LVL (1'b0),
    .PARITY_EN (1'b0)
  ) u_dut_plain (
    .clk(clk), .rst_n(rst_n), .in_enable(in_enable), .in_data(in_data),
    .out_bit(bit_n), .out_bit_valid(bitv_n), .out_byte(byte_n), .out_byte_valid(bytev_n),
    .last_bits(last_n), .parity_err(perr_n), .sof(sof_n), .eof(eof_n),
    .coding_err(cerr_n), .busy(busy_n)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] last;
    logic       perr;
    logic       with_eof;
  } byte_exp_t;

  logic      exp_bit_p[$];
  logic      exp_bit_n[$];
  byte_exp_t exp_byte_p[$];
  byte_exp_t exp_byte_n[$];

  int checks = 0;
  int errors = 0;
  int sof_cnt_p = 0, eof_cnt_p = 0, cerr_cnt_p = 0;
  int sof_cnt_n = 0, eof_cnt_n = 0, cerr_cnt_n = 0;
  int exp_sof = 0, exp_eof = 0, exp_cerr = 0;

  logic      mb_p, mb_n;
  byte_exp_t my_p, my_n;

  // Parity receiver monitor
  always @(negedge clk) begin
    if (sof_p) sof_cnt_p++;
    if (eof_p) eof_cnt_p++;
    if (cerr_p) begin
      cerr_cnt_p++;
      checks++;
      if (busy_p !== 1'b0 || eof_p !== 1'b0) begin
        errors++;
        $display("FAIL par_abort: busy=%0b eof=%0b, want 0 0", busy_p, eof_p);
      end
    end
    if (bitv_p) begin
      checks++;
      if (exp_bit_p.size() == 0) begin
        errors++;
        $display("FAIL par_bit: unexpected bit %0b, want none", bit_p);
      end else begin
        mb_p = exp_bit_p.pop_front();
        if (bit_p !== mb_p) begin
          errors++;
          $display("FAIL par_bit: got %0b want %0b", bit_p, mb_p);
        end
      end
    end
    if (bytev_p) begin
      checks++;
      if (exp_byte_p.size() == 0) begin
        errors++;
        $display("FAIL par_byte: unexpected byte %02h, want none", byte_p);
      end else begin
        my_p = exp_byte_p.pop_front();
        if ({byte_p, last_p, perr_p, eof_p} !== my_p) begin
          errors++;
          $display("FAIL par_byte: got byte=%02h last=%0d perr=%0b eof=%0b want %02h %0d %0b %0b",
                   byte_p, last_p, perr_p, eof_p, my_p.data, my_p.last, my_p.perr, my_p.with_eof);
        end
      end
    end
  end

  // Plain receiver monitor
  always @(negedge clk) begin
    if (sof_n) sof_cnt_n++;
    if (eof_n) eof_cnt_n++;
    if (cerr_n) begin
      cerr_cnt_n++;
      checks++;
      if (busy_n !== 1'b0 || eof_n !== 1'b0) begin
        errors++;
        $display("FAIL plain_abort: busy=%0b eof=%0b, want 0 0", busy_n, eof_n);
      end
    end
    if (bitv_n) begin
      checks++;
      if (exp_bit_n.size() == 0) begin
        errors++;
        $display("FAIL plain_bit: unexpected bit %0b, want none", bit_n);
      end else begin
        mb_n = exp_bit_n.pop_front();
        if (bit_n !== mb_n) begin
          errors++;
          $display("FAIL plain_bit: got %0b want %0b", bit_n, mb_n);
        end
      end
    end
    if (bytev_n) begin
      checks++;
      if (exp_byte_n.size() == 0) begin
        errors++;
        $display("FAIL plain_byte: unexpected byte %02h, want none", byte_n);
      end else begin
        my_n = exp_byte_n.pop_front();
        if ({byte_n, last_n, perr_n, eof_n} !== my_n) begin
          errors++;
          $display("FAIL plain_byte: got byte=%02h last=%0d perr=%0b eof=%0b want %02h %0d %0b %0b",
                   byte_n, last_n, perr_n, eof_n, my_n.data, my_n.last, my_n.perr, my_n.with_eof);
        end
      end
    end
  end

  // One ETU of line activity; off<0 means no pause, else a 2-cycle pause starting at offset off.
  task automatic drive_etu(input int off);
    for (int p = 0; p < Etu; p++) begin
      in_data = !(off >= 0 && p >= off && p < off + 2);
      @(posedge clk);
      #1;
    end
    in_data = 1'b1;
  endtask

  task automatic idle(input int n);
    in_data = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Byte model: full characters then an EOF flush of any remainder.
  task automatic push_bytes(input logic [31:0] d, input int n, input bit par);
    byte_exp_t e;
    int        sz;
    int        i;
    int        r;
    logic [7:0] mask;
    sz = par ? 9 : 8;
    i  = 0;
    while (n - i >= sz) begin
      e.data     = d[i +: 8];
      e.last     = 3'd0;
      e.perr     = par ? ~^d[i +: 9] : 1'b0;
      e.with_eof = 1'b0;
      if (par) exp_byte_p.push_back(e);
      else exp_byte_n.push_back(e);
      i += sz;
    end
    if (n > i) begin
      r          = n - i;
      mask       = (r >= 8) ? 8'hFF : 8'((1 << r) - 1);
      e.data     = d[i +: 8] & mask;
      e.last     = 3'(r % 8);
      e.perr     = 1'b0;
      e.with_eof = 1'b1;
      if (par) exp_byte_p.push_back(e);
      else exp_byte_n.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n);
    logic prev;
    for (int i = 0; i < n; i++) begin
      exp_bit_p.push_back(d[i]);
      exp_bit_n.push_back(d[i]);
    end
    push_bytes(d, n, 1'b1);
    push_bytes(d, n, 1'b0);
    exp_sof++;
    exp_eof++;
    drive_etu(0);
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (d[i]) drive_etu(Etu / 2);
      else if (prev) drive_etu(-1);
      else drive_etu(0);
      prev = d[i];
    end
    if (prev) drive_etu(-1);
    else drive_etu(0);
    drive_etu(-1);
    idle(2 * Etu);
  endtask

  task automatic test_reset();
    idle(4);
    checks++;
    if ({bit_p, bitv_p, byte_p, bytev_p, last_p, perr_p, sof_p, eof_p, cerr_p, busy_p} !== 19'd0) begin
      errors++;
      $display("FAIL reset_par: outputs %05h want 0",
               {bit_p, bitv_p, byte_p, bytev_p, last_p, perr_p, sof_p, eof_p, cerr_p, busy_p});
    end
    checks++;
    if ({bit_n, bitv_n, byte_n, bytev_n, last_n, perr_n, sof_n, eof_n, cerr_n, busy_n} !== 19'd0) begin
      errors++;
      $display("FAIL reset_plain: outputs %05h want 0",
               {bit_n, bitv_n, byte_n, bytev_n, last_n, perr_n, sof_n, eof_n, cerr_n, busy_n});
    end
    rst_n = 1'b1;
    in_enable = 1'b1;
    idle(Etu);
  endtask

  task automatic test_plain_frame();
    send_frame(32'h9, 4);
    checks++;
    if (exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size() != 0) begin
      errors++;
      $display("FAIL plain_frame_pending: %0d outputs unseen, want 0",
               exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size());
    end
    checks++;
    if ({sof_cnt_n, eof_cnt_n, cerr_cnt_n} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL plain_frame_events: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_n, eof_cnt_n, cerr_cnt_n, exp_sof, exp_eof, exp_cerr);
    end
  endtask

  task automatic test_parity();
    send_frame(32'h193, 9);
    send_frame(32'h093, 9);
    checks++;
    if (exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size() != 0) begin
      errors++;
      $display("FAIL parity_pending: %0d outputs unseen, want 0",
               exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size());
    end
    checks++;
    if ({sof_cnt_p, eof_cnt_p, cerr_cnt_p} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL parity_events: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_p, eof_cnt_p, cerr_cnt_p, exp_sof, exp_eof, exp_cerr);
    end
  endtask

  task automatic test_short_frame();
    send_frame(32'h26, 7);
    checks++;
    if (exp_byte_p.size() + exp_byte_n.size() + exp_bit_p.size() != 0) begin
      errors++;
      $display("FAIL short_pending: %0d outputs unseen, want 0",
               exp_byte_p.size() + exp_byte_n.size() + exp_bit_p.size());
    end
    checks++;
    if (eof_cnt_p !== exp_eof) begin
      errors++;
      $display("FAIL short_eof: eof count %0d want %0d", eof_cnt_p, exp_eof);
    end
  endtask

  task automatic test_coding_err();
    exp_sof++;
    exp_cerr++;
    drive_etu(0);
    drive_etu(Etu / 2);
    drive_etu(1);
    idle(3 * Etu);
    checks++;
    if ({sof_cnt_p, eof_cnt_p, cerr_cnt_p} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL cerr_events_par: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_p, eof_cnt_p, cerr_cnt_p, exp_sof, exp_eof, exp_cerr);
    end
    checks++;
    if ({sof_cnt_n, eof_cnt_n, cerr_cnt_n} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL cerr_events_plain: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_n, eof_cnt_n, cerr_cnt_n, exp_sof, exp_eof, exp_cerr);
    end
  endtask

  task automatic test_enable_drop();
    // Bits 1,1,0,1,0: the fifth is still held when the receiver is disabled.
    exp_bit_p.push_back(1'b1); exp_bit_p.push_back(1'b1);
    exp_bit_p.push_back(1'b0); exp_bit_p.push_back(1'b1);
    exp_bit_n.push_back(1'b1); exp_bit_n.push_back(1'b1);
    exp_bit_n.push_back(1'b0); exp_bit_n.push_back(1'b1);
    exp_sof++;
    drive_etu(0);
    drive_etu(Etu / 2);
    drive_etu(Etu / 2);
    drive_etu(-1);
    drive_etu(Etu / 2);
    drive_etu(-1);
    idle(4);
    in_enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bitv_p, bytev_p, perr_p, sof_p, eof_p, cerr_p, busy_p,
         bitv_n, bytev_n, perr_n, sof_n, eof_n, cerr_n, busy_n} !== 14'd0) begin
      errors++;
      $display("FAIL disable_strobes: par %07b plain %07b want 0",
               {bitv_p, bytev_p, perr_p, sof_p, eof_p, cerr_p, busy_p},
               {bitv_n, bytev_n, perr_n, sof_n, eof_n, cerr_n, busy_n});
    end
    idle(Etu);
    in_enable = 1'b1;
    idle(Etu);
    send_frame(32'h193, 9);
    checks++;
    if (exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size() != 0) begin
      errors++;
      $display("FAIL disable_pending: %0d outputs unseen, want 0",
               exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size());
    end
    checks++;
    if ({sof_cnt_p, eof_cnt_p, cerr_cnt_p} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL disable_events: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_p, eof_cnt_p, cerr_cnt_p, exp_sof, exp_eof, exp_cerr);
    end
  endtask

  task automatic test_mid_reset();
    exp_bit_p.push_back(1'b1); exp_bit_p.push_back(1'b0);
    exp_bit_n.push_back(1'b1); exp_bit_n.push_back(1'b0);
    exp_sof++;
    drive_etu(0);
    drive_etu(Etu / 2);
    drive_etu(-1);
    drive_etu(Etu / 2);
    idle(4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bit_p, bitv_p, byte_p, bytev_p, last_p, perr_p, sof_p, eof_p, cerr_p, busy_p,
         bit_n, bitv_n, byte_n, bytev_n, last_n, perr_n, sof_n, eof_n, cerr_n, busy_n} !== 38'd0)
    begin
      errors++;
      $display("FAIL midreset_outputs: par %05h plain %05h want 0",
               {bit_p, bitv_p, byte_p, bytev_p, last_p, perr_p, sof_p, eof_p, cerr_p, busy_p},
               {bit_n, bitv_n, byte_n, bytev_n, last_n, perr_n, sof_n, eof_n, cerr_n, busy_n});
    end
    rst_n = 1'b1;
    idle(2);
    send_frame(32'h26, 7);
    checks++;
    if (exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending: %0d outputs unseen, want 0",
               exp_bit_p.size() + exp_bit_n.size() + exp_byte_p.size() + exp_byte_n.size());
    end
    checks++;
    if ({sof_cnt_n, eof_cnt_n, cerr_cnt_n} !== {exp_sof, exp_eof, exp_cerr}) begin
      errors++;
      $display("FAIL midreset_events: sof/eof/err %0d/%0d/%0d want %0d/%0d/%0d",
               sof_cnt_n, eof_cnt_n, cerr_cnt_n, exp_sof, exp_eof, exp_cerr);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_plain_frame();
    test_parity();
    test_short_frame();
    test_coding_err();
    test_enable_drop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
